// File: rtl/alu_logic_sequencer.sv
// Bit-serial-by-chunk logic unit: a wide XOR/OR/AND/NOT is computed on one
// SLICE-bit slice, one chunk per cycle, LSB chunk first.

module alu_logic_slice #(
    parameter int N = 4
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         en_xor_i,
    input  logic         en_or_i,
    input  logic         en_and_i,
    input  logic         en_not_i,
    output logic [N-1:0] y_o
);
    assign y_o = ({N{en_xor_i}} & (a_i ^ b_i))
               | ({N{en_or_i}}  & (a_i | b_i))
               | ({N{en_and_i}} & (a_i & b_i))
               | ({N{en_not_i}} & (~a_i));
endmodule

module alu_logic_sequencer #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             busy,
    output logic [1:0]       dbg_state,
    output logic [3:0]       dbg_enables
);
    localparam int CHUNKS = WIDTH / SLICE;
    localparam int IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic [SLICE-1:0]   slice_a, slice_b, slice_y;
    logic               en_xor, en_or, en_and, en_not;

    alu_logic_slice #(.N(SLICE)) u_slice (
        .a_i      (slice_a),
        .b_i      (slice_b),
        .en_xor_i (en_xor),
        .en_or_i  (en_or),
        .en_and_i (en_and),
        .en_not_i (en_not),
        .y_o      (slice_y)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        en_xor   = 1'b0;
        en_or    = 1'b0;
        en_and   = 1'b0;
        en_not   = 1'b0;
        slice_a  = a_q[idx_q*SLICE +: SLICE];
        slice_b  = b_q[idx_q*SLICE +: SLICE];

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    a_d     = req_a;
                    b_d     = req_b;
                    op_d    = req_op;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                case (op_q)
                    2'b00:   en_xor = 1'b1;
                    2'b01:   en_or  = 1'b1;
                    2'b10:   en_and = 1'b1;
                    default: en_not = 1'b1;
                endcase
                // Unwritten chunks keep the previous result until overwritten.
                result_d[idx_q*SLICE +: SLICE] = slice_y;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready   = (state_q == IDLE);
    assign rsp_valid   = (state_q == DONE);
    assign busy        = (state_q == RUN) || (state_q == DONE);
    assign rsp_result  = result_q;
    assign dbg_state   = state_q;
    assign dbg_enables = {en_xor, en_or, en_and, en_not};
endmodule

// File: tb/tb_alu_logic_sequencer.sv
// Randomized bench for alu_logic_sequencer (16/4 and 8/8 instances) checked
// against a whole-word reference model.

module tb_alu_logic_sequencer;
    localparam int W      = 16;
    localparam int S      = 4;
    localparam int CHUNKS = W / S;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = 2'b00;
    logic [W-1:0]  req_a = '0;
    logic [W-1:0]  req_b = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [W-1:0]  rsp_result;
    logic          busy;
    logic [1:0]    dbg_state;
    logic [3:0]    dbg_enables;

    logic          req_valid8 = 1'b0;
    logic          req_ready8;
    logic [1:0]    req_op8 = 2'b00;
    logic [7:0]    req_a8 = '0;
    logic [7:0]    req_b8 = '0;
    logic          rsp_valid8;
    logic          rsp_ready8 = 1'b1;
    logic [7:0]    rsp_result8;
    logic          busy8;
    logic [1:0]    dbg_state8;
    logic [3:0]    dbg_enables8;

    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    logic [W-1:0]  prev_result = '0;
    logic [W-1:0]  exp_q[$];

    alu_logic_sequencer #(.WIDTH(W), .SLICE(S)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .busy(busy), .dbg_state(dbg_state), .dbg_enables(dbg_enables)
    );

    alu_logic_sequencer #(.WIDTH(8), .SLICE(8)) dut8 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid8), .req_ready(req_ready8), .req_op(req_op8),
        .req_a(req_a8), .req_b(req_b8),
        .rsp_valid(rsp_valid8), .rsp_ready(rsp_ready8), .rsp_result(rsp_result8),
        .busy(busy8), .dbg_state(dbg_state8), .dbg_enables(dbg_enables8)
    );

    // Clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] low_mask(input int bits);
        return (bits >= 32) ? 32'hFFFF_FFFF : ((32'h1 << bits) - 32'h1);
    endfunction

    // Whole-word reference: result of the op on the full operands.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input int w);
        logic [31:0] r;
        case (op)
            2'b00:   r = a ^ b;
            2'b01:   r = a | b;
            2'b10:   r = a & b;
            default: r = ~a;
        endcase
        return r & low_mask(w);
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] op);
        logic [3:0] base;
        base = 4'b1000;
        return base >> op;
    endfunction

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Driver: caller sits at a negedge with the DUT in IDLE.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int hold, input bit keep_valid, output int rise_cyc);
        logic [W-1:0] exp;
        logic [W-1:0] part;
        logic [W-1:0] m;
        int c;
        check("idle_ready", req_ready, 1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        exp       = W'(model(op, a, b, W));
        exp_q.push_back(exp);
        tick();
        req_valid = keep_valid;
        req_op    = 2'($urandom_range(0, 3));
        req_a     = W'($urandom);
        req_b     = W'($urandom);
        c = 1;
        while (!rsp_valid && c <= CHUNKS + 4) begin
            rsp_ready = 1'($urandom_range(0, 1));
            if (c <= CHUNKS) begin
                m    = W'(low_mask((c - 1) * S));
                part = (exp & m) | (prev_result & ~m);
                check("run_enable", dbg_enables, onehot(op));
                check("run_busy", busy, 1);
                check("run_req_ready", req_ready, 0);
                check("run_partial", rsp_result, part);
            end
            tick();
            c++;
        end
        check("latency", c, CHUNKS + 1);
        rise_cyc = cyc;
        for (int h = 0; h < hold; h++) begin
            rsp_ready = 1'b0;
            check("hold_valid", rsp_valid, 1);
            check("hold_result", rsp_result, exp);
            check("hold_req_ready", req_ready, 0);
            check("hold_enable", dbg_enables, 0);
            req_valid = 1'b1;
            tick();
            req_valid = keep_valid;
        end
        rsp_ready = 1'b1;
        check("done_valid", rsp_valid, 1);
        check("done_busy", busy, 1);
        check("done_result", rsp_result, exp_q.pop_front());
        tick();
        check("post_valid", rsp_valid, 0);
        check("post_ready", req_ready, 1);
        check("post_busy", busy, 0);
        prev_result = exp;
    endtask

    task automatic run8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int c;
        req_valid8 = 1'b1;
        req_op8    = op;
        req_a8     = a;
        req_b8     = b;
        tick();
        req_valid8 = 1'b0;
        c = 1;
        while (!rsp_valid8 && c <= 6) begin
            check("w8_enable", dbg_enables8, onehot(op));
            tick();
            c++;
        end
        check("w8_latency", c, 2);
        check("w8_result", rsp_result8, model(op, a, b, 8));
        tick();
        check("w8_post_valid", rsp_valid8, 0);
    endtask

    initial begin
        int r1, r2, rd;
        int saw_valid;
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_result", rsp_result, 0);
        check("rst_enables", dbg_enables, 0);
        reset = 1'b0;
        tick();

        run_op(2'b00, 16'hA5F0, 16'h0FF0, 0, 1'b0, rd);
        run_op(2'b11, 16'h1234, 16'hFFFF, 0, 1'b0, rd);
        run_op(2'b11, 16'h1234, 16'h0000, 0, 1'b0, rd);
        run_op(2'b10, 16'hFF00, 16'h0F0F, 3, 1'b0, rd);
        run_op(2'b10, 16'hFF00, 16'h0F0F, 0, 1'b1, r1);
        run_op(2'b01, 16'h00F0, 16'h0001, 0, 1'b0, r2);
        check("b2b_spacing", r2 - r1, CHUNKS + 2);

        // Abandon an operation after two chunks.
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_a     = W'($urandom);
        req_b     = W'($urandom);
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("midrst_valid", rsp_valid, 0);
        check("midrst_ready", req_ready, 1);
        check("midrst_busy", busy, 0);
        check("midrst_result", rsp_result, 0);
        check("midrst_enables", dbg_enables, 0);
        reset = 1'b0;
        saw_valid = 0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid) saw_valid = 1;
            tick();
        end
        check("midrst_no_rsp", saw_valid, 0);
        prev_result = '0;

        // Reset beats a simultaneous request.
        reset     = 1'b1;
        req_valid = 1'b1;
        tick();
        check("rst_vs_req_busy", busy, 0);
        check("rst_vs_req_ready", req_ready, 1);
        reset     = 1'b0;
        req_valid = 1'b0;
        tick();
        check("rst_vs_req_idle", busy, 0);

        for (int i = 0; i < 25; i++) begin
            run_op(2'($urandom_range(0, 3)), W'($urandom), W'($urandom),
                   $urandom_range(0, 2), 1'b0, rd);
        end

        run8(2'b01, 8'hC3, 8'h3C);
        for (int i = 0; i < 6; i++) begin
            run8(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
        end

        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
